// File: rtl/aes_defs_pkg.sv
// Shared AES definitions: key-length codes, round bounds, scheduler state
// encoding and the captured-request context used by aes_decipher_sched.
package aes_defs_pkg;

    localparam logic [3:0] AES_128_BIT_KEY = 4'h0;
    localparam logic [3:0] AES_192_BIT_KEY = 4'h1;
    localparam logic [3:0] AES_256_BIT_KEY = 4'h2;

    localparam int         AES_MAX_ROUND     = 14;
    localparam logic [3:0] AES_MAX_ROUND_IDX = 4'd14;

    // Scheduler FSM encoding (kept as plain constants for legacy tools).
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    // Everything latched from the winning requester at grant time.
    typedef struct packed {
        logic         id;
        logic [3:0]   keylen;
        logic [127:0] block;
    } aes_req_ctx_t;

    // True when a round-key index addresses a real key_mem entry.
    function automatic logic round_in_range(input logic [3:0] idx);
        return (idx <= AES_MAX_ROUND_IDX);
    endfunction

endpackage

// File: rtl/aes_round_key_mem.sv
// 15 x 128-bit round-key store. One synchronous write port, one
// combinational read port; reads of index 15 return zero. The array is
// intentionally not reset so keys survive a scheduler reset.
module aes_round_key_mem
    import aes_defs_pkg::*;
(
    input  logic         clk,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [127:0] wdata,
    input  logic [3:0]   raddr,
    output logic [127:0] rdata
);

    logic [127:0] mem_r [0:AES_MAX_ROUND];
    logic [127:0] rdata_s;

    // Write port: out-of-range addresses are ignored here as a second guard.
    always_ff @(posedge clk) begin
        if (we && round_in_range(waddr)) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Async read port with zero for the unused index 15.
    always_comb begin
        rdata_s = 128'd0;
        if (round_in_range(raddr)) begin
            rdata_s = mem_r[raddr];
        end else begin
            rdata_s = 128'd0;
        end
    end

    assign rdata = rdata_s;

endmodule

// File: rtl/aes_decipher_sched.sv
// Round-robin scheduler sharing one decipher core between two requesters.
// Owns the round-key memory, drives the core's next handshake, watches
// ready with a timeout, and returns tagged plaintext on a valid/ready port.
module aes_decipher_sched
    import aes_defs_pkg::*;
#(
    parameter int NEXT_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   cfg_keylen,
    input  logic         key_we,
    input  logic [3:0]   key_addr,
    input  logic [127:0] key_wdata,
    output logic         key_wr_err,
    input  logic         req0_valid,
    input  logic [127:0] req0_block,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_block,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_block,
    output logic         rsp_err,
    output logic         dc_next,
    output logic [3:0]   dc_keylen,
    output logic [127:0] dc_block,
    input  logic [3:0]   dc_round,
    output logic [127:0] dc_round_key,
    input  logic [127:0] dc_new_block,
    input  logic         dc_ready,
    output logic         busy
);

    localparam logic [7:0] NEXT_LAST    = 8'(NEXT_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] TIMER_MAX    = 8'hFF;

    logic [2:0]   state_r;
    logic [2:0]   state_nxt_s;
    logic         rr_r;
    logic [7:0]   timer_r;
    aes_req_ctx_t ctx_r;

    logic         grant0_s;
    logic         grant1_s;
    logic         capture_s;
    logic         abort_s;
    logic         key_wr_ok_s;

    logic         dc_next_r;
    logic         busy_r;
    logic         key_wr_err_r;
    logic         rsp_valid_r;
    logic         rsp_err_r;
    logic         rsp_id_r;
    logic [127:0] rsp_block_r;

    // Keys may only change while the core is not reading them.
    assign key_wr_ok_s = key_we && (state_r == ST_IDLE) && round_in_range(key_addr);

    aes_round_key_mem u_key_mem (
        .clk   (clk),
        .we    (key_wr_ok_s),
        .waddr (key_addr),
        .wdata (key_wdata),
        .raddr (dc_round),
        .rdata (dc_round_key)
    );

    // Arbiter: single requester wins outright, a tie goes to the rr favourite.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = ~rr_r;
                grant1_s = rr_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Ready is the grant itself; masked during reset so no block is
    // reported as taken while the capture registers are held clear.
    assign req0_ready = grant0_s & ~reset;
    assign req1_ready = grant1_s & ~reset;

    // Next-state logic plus one-cycle capture/abort strobes for the response.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (timer_r == NEXT_LAST) begin
                    state_nxt_s = ST_WAIT_BUSY;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_BUSY: begin
                if (!dc_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (timer_r == TIMEOUT_LAST) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (dc_ready) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (timer_r == TIMEOUT_LAST) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Per-state cycle timer: restarts on every transition, saturates at max.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= 8'd0;
        end else if (state_nxt_s != state_r) begin
            timer_r <= 8'd0;
        end else if (timer_r != TIMER_MAX) begin
            timer_r <= timer_r + 8'd1;
        end
    end

    // Round-robin pointer: after a grant, favour the other requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_r <= 1'b0;
        end else if (grant0_s) begin
            rr_r <= 1'b1;
        end else if (grant1_s) begin
            rr_r <= 1'b0;
        end
    end

    // Latch block, id and key length at grant; held until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctx_r <= '0;
        end else if (grant1_s) begin
            ctx_r.id     <= 1'b1;
            ctx_r.keylen <= cfg_keylen;
            ctx_r.block  <= req1_block;
        end else if (grant0_s) begin
            ctx_r.id     <= 1'b0;
            ctx_r.keylen <= cfg_keylen;
            ctx_r.block  <= req0_block;
        end
    end

    // Registered core strobe, busy flag and key-write rejection pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_next_r    <= 1'b0;
            busy_r       <= 1'b0;
            key_wr_err_r <= 1'b0;
        end else begin
            dc_next_r    <= (state_nxt_s == ST_ISSUE);
            busy_r       <= (state_nxt_s != ST_IDLE);
            key_wr_err_r <= key_we && !key_wr_ok_s;
        end
    end

    // Response register: load on completion or abort, clear on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_block_r <= 128'd0;
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_id_r    <= ctx_r.id;
            rsp_block_r <= dc_new_block;
        end else if (abort_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_id_r    <= ctx_r.id;
            rsp_block_r <= 128'd0;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end
    end

    assign dc_next    = dc_next_r;
    assign dc_keylen  = ctx_r.keylen;
    assign dc_block   = ctx_r.block;
    assign busy       = busy_r;
    assign key_wr_err = key_wr_err_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_block  = rsp_block_r;

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Directed bench for aes_decipher_sched with a behavioural stand-in core.
// The stand-in walks rounds nr..0 reading dc_round_key, XOR-accumulates the
// keys, and returns block ^ acc; the FIPS-197 ciphertext with the full
// FIPS-197 schedule returns the FIPS-197 plaintext.
module tb_aes_decipher_sched;

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   cfg_keylen;
    logic         key_we;
    logic [3:0]   key_addr;
    logic [127:0] key_wdata;
    logic         key_wr_err;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [127:0] req0_block, req1_block;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [127:0] rsp_block;
    logic         dc_next;
    logic [3:0]   dc_keylen;
    logic [127:0] dc_block;
    logic [3:0]   dc_round;
    logic [127:0] dc_round_key;
    logic [127:0] dc_new_block;
    logic         dc_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] K [11];
    logic [127:0] kx;

    // stand-in core state
    logic         m_run, m_stuck;
    logic [3:0]   m_round, tb_round;
    logic [127:0] m_blk, m_acc;

    always #5 clk = ~clk;

    aes_decipher_sched dut (
        .clk(clk), .reset(reset), .cfg_keylen(cfg_keylen),
        .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata), .key_wr_err(key_wr_err),
        .req0_valid(req0_valid), .req0_block(req0_block), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_block(req1_block), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_block(rsp_block), .rsp_err(rsp_err),
        .dc_next(dc_next), .dc_keylen(dc_keylen), .dc_block(dc_block),
        .dc_round(dc_round), .dc_round_key(dc_round_key),
        .dc_new_block(dc_new_block), .dc_ready(dc_ready), .busy(busy)
    );

    function automatic logic [127:0] mock_result(input logic [127:0] b, input logic [127:0] acc);
        if (b == FIPS_CT && acc == kx) return FIPS_PT;
        return b ^ acc;
    endfunction

    assign dc_round = m_run ? m_round : tb_round;

    // stand-in decipher core
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0; dc_ready <= 1'b1; dc_new_block <= 128'd0;
            m_round <= 4'd0; m_blk <= 128'd0; m_acc <= 128'd0;
        end else if (!m_run) begin
            if (dc_next && !m_stuck) begin
                m_run <= 1'b1; dc_ready <= 1'b0; m_blk <= dc_block; m_acc <= 128'd0;
                m_round <= (dc_keylen == 4'h2) ? 4'd14 : 4'd10;
            end
        end else if (m_round == 4'd0) begin
            m_run <= 1'b0; dc_ready <= 1'b1;
            dc_new_block <= mock_result(m_blk, m_acc ^ dc_round_key);
        end else begin
            m_acc <= m_acc ^ dc_round_key;
            m_round <= m_round - 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input int id, input logic [127:0] blk);
        int n;
        logic seen;
        n = 0; seen = 1'b0;
        if (id == 0) begin req0_valid = 1'b1; req0_block = blk; end
        else begin req1_valid = 1'b1; req1_block = blk; end
        while (!seen && n < 50) begin
            @(negedge clk); n++;
            seen = (id == 0) ? req0_ready : req1_ready;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("grant_seen", {127'd0, seen}, 128'd1);
    endtask

    task automatic wait_rsp(output int n, output int nx);
        n = 0; nx = 0;
        do begin
            @(negedge clk); n++;
            if (dc_next) nx++;
        end while (!rsp_valid && n < 600);
    endtask

    initial begin
        int n, nx, n0, n1;
        logic r0, r1;
        int got_ord[$];
        int got_id[$];
        logic [127:0] got_blk[$];
        logic [127:0] t2a [2];
        logic [127:0] t2b [2];
        logic [127:0] snap, expb;

        K[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        K[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        K[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        K[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        K[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        K[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        K[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        K[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        K[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        K[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        K[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        kx = 128'd0;
        for (int i = 0; i < 11; i++) kx = kx ^ K[i];

        t2a[0] = 128'h11111111_22222222_33333333_44444444;
        t2a[1] = 128'h55555555_66666666_77777777_88888888;
        t2b[0] = 128'hdeadbeef_00000001_cafef00d_00000002;
        t2b[1] = 128'h0badc0de_12345678_9abcdef0_0f1e2d3c;

        cfg_keylen = 4'h0; key_we = 1'b0; key_addr = 4'd0; key_wdata = 128'd0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_block = 128'd0; req1_block = 128'd0;
        rsp_ready = 1'b1; m_stuck = 1'b0; tb_round = 4'd0;

        // ---- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp", {124'd0, rsp_valid, rsp_err, rsp_id, busy}, 128'd0);
        chk("rst_misc", {125'd0, dc_next, key_wr_err, req0_ready | req1_ready}, 128'd0);
        chk("rst_dc_block", dc_block, 128'd0);
        chk("rst_dc_keylen", {124'd0, dc_keylen}, 128'd0);
        chk("rst_rsp_block", rsp_block, 128'd0);
        @(posedge clk); #1; reset = 1'b0;

        // ---- T1: load FIPS-197 schedule and decipher one block
        for (int i = 0; i < 11; i++) begin
            key_we = 1'b1; key_addr = 4'(i); key_wdata = K[i];
            tick();
        end
        key_we = 1'b0;
        @(negedge clk);
        chk("t1_key_err", {127'd0, key_wr_err}, 128'd0);
        tb_round = 4'd10;
        #1 chk("t1_rk10", dc_round_key, K[10]);
        tick();
        issue(0, FIPS_CT);
        wait_rsp(n, nx);
        chk("t1_valid", {127'd0, rsp_valid}, 128'd1);
        chk("t1_id", {127'd0, rsp_id}, 128'd0);
        chk("t1_block", rsp_block, FIPS_PT);
        chk("t1_err", {127'd0, rsp_err}, 128'd0);
        chk("t1_next_cycles", 128'(nx), 128'd2);
        chk("t1_latency", 128'(n), 128'd14);
        tick();
        @(negedge clk);
        chk("t1_idle", {126'd0, busy, rsp_valid}, 128'd0);

        // ---- T2: contention from reset, four back-to-back blocks
        tick(); reset = 1'b1; tick(); reset = 1'b0;
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req0_block = t2a[0];
        req1_valid = 1'b1; req1_block = t2b[0];
        for (int c = 0; c < 400 && got_id.size() < 4; c++) begin
            @(negedge clk);
            r0 = req0_ready; r1 = req1_ready;
            if (r0) got_ord.push_back(0);
            if (r1) got_ord.push_back(1);
            if (rsp_valid) begin got_id.push_back(int'(rsp_id)); got_blk.push_back(rsp_block); end
            @(posedge clk); #1;
            if (r0) begin n0++; if (n0 < 2) req0_block = t2a[n0]; else req0_valid = 1'b0; end
            if (r1) begin n1++; if (n1 < 2) req1_block = t2b[n1]; else req1_valid = 1'b0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t2_grants", 128'(got_ord.size()), 128'd4);
        chk("t2_rsps", 128'(got_id.size()), 128'd4);
        chk("t2_ready0", 128'(n0), 128'd2);
        chk("t2_ready1", 128'(n1), 128'd2);
        for (int i = 0; i < 4; i++) begin
            expb = ((i % 2) == 0) ? t2a[i / 2] : t2b[i / 2];
            chk("t2_order", 128'(got_ord[i]), 128'(i % 2));
            chk("t2_rsp_id", 128'(got_id[i]), 128'(i % 2));
            chk("t2_rsp_block", got_blk[i], expb ^ kx);
        end

        // ---- T3: backpressure on the response port
        rsp_ready = 1'b0;
        issue(0, 128'hc3c3c3c3_00000000_ffffffff_12121212);
        wait_rsp(n, nx);
        snap = rsp_block;
        chk("t3_block", snap, 128'hc3c3c3c3_00000000_ffffffff_12121212 ^ kx);
        req1_valid = 1'b1; req1_block = 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; @(negedge clk);
            chk("t3_hold_valid", {127'd0, rsp_valid}, 128'd1);
            chk("t3_hold_block", rsp_block, snap);
            chk("t3_no_ready", {127'd0, req1_ready}, 128'd0);
        end
        rsp_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req1_ready && n < 20);
        chk("t3_regrant_gap", 128'(n), 128'd1);
        @(posedge clk); #1; req1_valid = 1'b0;
        wait_rsp(n, nx);
        chk("t3_r1_id", {127'd0, rsp_id}, 128'd1);
        chk("t3_r1_block", rsp_block, 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0 ^ kx);
        tick();

        // ---- T4: rejected key writes, out-of-range read, grant+write same cycle
        tick();
        key_we = 1'b1; key_addr = 4'd15; key_wdata = {4{32'hbad0bad0}};
        tick(); key_we = 1'b0;
        @(negedge clk);
        chk("t4_err_addr15", {127'd0, key_wr_err}, 128'd1);
        tick(); @(negedge clk);
        chk("t4_err_clear", {127'd0, key_wr_err}, 128'd0);
        issue(0, 128'h44444444_44444444_44444444_44444444);
        key_we = 1'b1; key_addr = 4'd3; key_wdata = {4{32'hbad0bad0}};
        tick(); key_we = 1'b0;
        @(negedge clk);
        chk("t4_err_busy", {127'd0, key_wr_err}, 128'd1);
        wait_rsp(n, nx);
        chk("t4_block", rsp_block, 128'h44444444_44444444_44444444_44444444 ^ kx);
        tick();
        tb_round = 4'd3;
        @(negedge clk);
        chk("t4_rk3", dc_round_key, K[3]);
        tb_round = 4'd15;
        #1 chk("t4_rk15", dc_round_key, 128'd0);
        tb_round = 4'd0;
        tick();
        key_we = 1'b1; key_addr = 4'd0; key_wdata = 128'h99999999_88888888_77777777_66666666;
        issue(0, 128'h12345678_12345678_12345678_12345678);
        key_we = 1'b0;
        wait_rsp(n, nx);
        chk("t4_same_cycle_key", rsp_block,
            128'h12345678_12345678_12345678_12345678 ^ kx ^ K[0] ^ 128'h99999999_88888888_77777777_66666666);
        tick();
        key_we = 1'b1; key_addr = 4'd0; key_wdata = K[0];
        tick(); key_we = 1'b0;

        // ---- T5: core never drops ready -> timeout abort
        m_stuck = 1'b1; cfg_keylen = 4'h2;
        issue(1, 128'h77777777_77777777_77777777_77777777);
        cfg_keylen = 4'h0;
        wait_rsp(n, nx);
        chk("t5_valid", {127'd0, rsp_valid}, 128'd1);
        chk("t5_err", {127'd0, rsp_err}, 128'd1);
        chk("t5_block", rsp_block, 128'd0);
        chk("t5_id", {127'd0, rsp_id}, 128'd1);
        chk("t5_latency", 128'(n), 128'd258);
        chk("t5_keylen_held", {124'd0, dc_keylen}, 128'h2);
        tick(); @(negedge clk);
        chk("t5_idle", {125'd0, busy, rsp_valid, rsp_err}, 128'd0);
        m_stuck = 1'b0;

        // ---- T6: asynchronous reset during WAIT_DONE, then a clean request
        tick();
        issue(0, 128'hfeedface_feedface_feedface_feedface);
        repeat (6) @(negedge clk);
        chk("t6_busy_before", {127'd0, busy}, 128'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_ctrl", {124'd0, busy, rsp_valid, rsp_err, dc_next}, 128'd0);
        chk("t6_rst_block", dc_block, 128'd0);
        chk("t6_rst_rsp_block", rsp_block, 128'd0);
        @(posedge clk); @(posedge clk); #1; reset = 1'b0;
        issue(1, 128'h01020304_05060708_090a0b0c_0d0e0f10);
        wait_rsp(n, nx);
        chk("t6_after_id", {127'd0, rsp_id}, 128'd1);
        chk("t6_after_block", rsp_block, 128'h01020304_05060708_090a0b0c_0d0e0f10 ^ kx);
        chk("t6_after_err", {127'd0, rsp_err}, 128'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
